mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified single-port memory between the fetch stage and the memory stage.
//  Each side issues a request; a FSM grants one transaction at a time and drives the memory port.
//  The FSM also returns read data and raises stall requests to the hazard logic.
//  Data side has priority; a starvation counter guarantees fetch forward progress.
// PARAMETERS
//  DATA_WIDTH  32  data/address width of memory port and data requester
//  ROM_WIDTH   12  fetch address width (zero-extended onto mem_addr)
//  MAX_STARVE  4   consecutive D grants with fetch pending before fetch is forced to win
//  TIMEOUT     64  cycles without mem_ack before a transaction is aborted
// PORTS
//  clk        in   1           clock, all state on posedge
//  rst        in   1           synchronous reset, active-high
//  if_req     in   1           fetch read request (level, held until if_valid)
//  if_addr    in   ROM_WIDTH   fetch address
//  if_rdata   out  DATA_WIDTH  fetched instruction, valid with if_valid
//  if_valid   out  1           one-cycle pulse: fetch complete
//  d_req      in   1           data request (level, held until d_valid)
//  d_we       in   1           1=store, 0=load
//  d_addr     in   DATA_WIDTH  data address
//  d_wdata    in   DATA_WIDTH  store data
//  d_rdata    out  DATA_WIDTH  load data, valid with d_valid
//  d_valid    out  1           one-cycle pulse: data access complete
//  stall_if   out  1           comb: if_req && !if_valid
//  stall_d    out  1           comb: d_req && !d_valid
//  mem_req    out  1           registered; high for whole transaction
//  mem_we     out  1           registered write enable
//  mem_addr   out  DATA_WIDTH  registered address
//  mem_wdata  out  DATA_WIDTH  registered write data
//  mem_rdata  in   DATA_WIDTH  memory read data, sampled on mem_ack
//  mem_ack    in   1           memory completion, one cycle
//  err        out  1           one-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset: state=IDLE.
//   starve_cnt=0 and tmo_cnt=0.
//   mem_req, mem_we, if_valid, d_valid and err are 0.
//   mem_addr, mem_wdata, if_rdata and d_rdata are 0.
//  States: IDLE, BUSY_I, BUSY_D.
//  IDLE grant, decided in one cycle; mem_* registered, so mem_req rises the cycle after the request:
//   d_req && !(if_req && starve_cnt==MAX_STARVE) -> BUSY_D; latch d_we/d_addr/d_wdata.
//   else if_req -> BUSY_I; mem_we=0, mem_addr={0,if_addr}.
//   else remain IDLE, mem_req=0.
//  BUSY_x: hold mem_* stable. On mem_ack:
//   capture mem_rdata into if_rdata or d_rdata (d_rdata also updated on stores).
//   pulse the matching valid next cycle.
//   mem_req=0 and return to IDLE (one idle bubble between transactions).
//  Minimum latency req->valid: 3 cycles (grant, mem_req+ack, valid).
//  starve_cnt: +1 on each D grant while if_req high; saturates at MAX_STARVE; cleared on I grant.
//  tmo_cnt: counts BUSY cycles without ack. On reaching TIMEOUT:
//   pulse err, deassert mem_req, return to IDLE.
//   No valid pulse; the requester re-arbitrates.
//  mem_ack while IDLE is ignored.
//  A request dropped mid-transaction is not cancelled; the transaction completes and valid still pulses.
//  Simultaneous if_req and d_req are resolved as above; no grant is issued in the same cycle as a completion.
//  rst mid-transaction: mem_req low next cycle, no valid pulse; memory must tolerate abandonment.
// TESTING
//  1. Lone fetch, if_addr=0x010, ack after 2 cycles, rdata=0x00500093:
//     mem_addr=0x10, mem_we=0; if_valid pulses once; if_rdata=0x00500093.
//  2. Simultaneous if_req+d_req load at 0x100:
//     D served first (mem_addr=0x100); fetch follows after one bubble.
//  3. d_req held high with if_req high, MAX_STARVE=4:
//     4 D grants, then 5th grant goes to I; starve_cnt clears to 0.
//  4. Store d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF:
//     mem_we=1 and mem_wdata stable until ack; stall_d=1 until d_valid.
//  5. No ack for 64 cycles: err pulses once, mem_req drops, state IDLE, no valid.
//  6. rst asserted while BUSY_I: next cycle all outputs 0; later ack ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one single-port memory shared by fetch and data requesters
//
// Purpose: a three-state FSM grants one memory transaction at a time, drives the
// registered memory port, returns read data with a one-cycle valid pulse and raises
// stalls while a requester is waiting. Data has priority; a starvation counter forces
// a fetch grant after MAX_STARVE data grants issued with fetch pending. A transaction
// without mem_ack for TIMEOUT busy cycles is aborted with an err pulse.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req, if_addr               fetch read request (level) and address
//   if_rdata, if_valid            fetched word and completion pulse
//   d_req, d_we, d_addr, d_wdata  data request (level), store flag, address, store data
//   d_rdata, d_valid              data read word and completion pulse
//   stall_if, stall_d             requester is waiting (comb)
//   mem_req, mem_we, mem_addr,
//   mem_wdata                     registered memory port, held for a whole transaction
//   mem_rdata, mem_ack            memory read data and one-cycle completion
//   err                           one-cycle pulse on timeout abort
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ROM_WIDTH  = 12,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ROM_WIDTH-1:0]  if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_valid,
  output logic                  stall_if,
  output logic                  stall_d,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  err
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          grant_d, grant_i, done, abort;

  assign stall_if = if_req && !if_valid;
  assign stall_d  = d_req && !d_valid;

  // While a valid pulse is out, the finished requester still shows its request
  // level; granting then would replay the same access, hence the idle bubble.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (!if_valid && !d_valid) begin
          if (d_req && !(if_req && starve_cnt == STARVE_MAX)) begin
            grant_d   = 1'b1;
            state_nxt = BUSY_D;
          end else if (if_req) begin
            grant_i   = 1'b1;
            state_nxt = BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      err        <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        tmo_cnt   <= '0;
        if (if_req && starve_cnt != STARVE_MAX) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else if (grant_i) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= {{(DATA_WIDTH-ROM_WIDTH){1'b0}}, if_addr};
        starve_cnt <= '0;
        tmo_cnt    <= '0;
      end else if (done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        tmo_cnt <= '0;
        // Stores also return mem_rdata, so d_rdata follows every data completion.
        if (state == BUSY_I) begin
          if_rdata <= mem_rdata;
          if_valid <= 1'b1;
        end else begin
          d_rdata <= mem_rdata;
          d_valid <= 1'b1;
        end
      end else if (abort) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        err     <= 1'b1;
        tmo_cnt <= '0;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule
